// File: rtl/pipeline_hazard_ctrl_pkg.sv
//============================================================================
// Module  : hazard_pkg
// Brief   : Shared state encoding, forwarding selects and helpers for the
//           pipeline hazard controller.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MD_BUSY    = 2'd2,
    HALTED     = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // The youngest producer (EX) always wins over the older one (MEM).
  function automatic logic [1:0] fwd_sel(input logic ex_rel, input logic mem_rel);
    if (ex_rel)       return FWD_EX;
    else if (mem_rel) return FWD_MEM;
    else              return FWD_RF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
//============================================================================
// Module  : pipeline_hazard_ctrl_if
// Brief   : Hazard event inputs and pipeline control outputs bundle.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             R1_EX_Related;
  logic             R1_MEM_Related;
  logic             R2_EX_Related;
  logic             R2_MEM_Related;
  logic             EX_MemRead;
  logic             Branch_Taken;
  logic             MulDiv_Start;
  logic             Halt;
  logic             PC_En;
  logic             IFID_En;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic [1:0]       R1_Fwd;
  logic [1:0]       R2_Fwd;
  logic             Halted;
  logic [CNT_W-1:0] Stall_Cnt;
  logic [CNT_W-1:0] Flush_Cnt;

  modport master (
    output R1_EX_Related, R1_MEM_Related, R2_EX_Related, R2_MEM_Related,
           EX_MemRead, Branch_Taken, MulDiv_Start, Halt,
    input  PC_En, IFID_En, IFID_Flush, IDEX_Flush, R1_Fwd, R2_Fwd, Halted,
           Stall_Cnt, Flush_Cnt
  );

  modport slave (
    input  R1_EX_Related, R1_MEM_Related, R2_EX_Related, R2_MEM_Related,
           EX_MemRead, Branch_Taken, MulDiv_Start, Halt,
    output PC_En, IFID_En, IFID_Flush, IDEX_Flush, R1_Fwd, R2_Fwd, Halted,
           Stall_Cnt, Flush_Cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
//============================================================================
// Module  : hazard_perf_cnt
// Brief   : Saturating event counter with increment enable.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             inc,
  output logic      [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (inc && (r_count != {CNT_W{1'b1}}))
      r_count <= r_count + 1'b1;
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
//============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Stall/flush/forward sequencer for the 5-stage pipeline.
//           Optional perf counters enabled by HAZARD_PERF_CNT_EN.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input wire logic              clk,
  input wire logic              rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int         c_MD_W    = 4;
  localparam logic [3:0] c_MD_LOAD = 4'(MD_LATENCY - 1);

  state_t            r_state, w_next;
  logic [c_MD_W-1:0] r_md_cnt, w_md_cnt_nxt;
  logic              w_pc_en, w_ifid_en, w_ifid_flush, w_idex_flush, w_halted;
  logic [1:0]        w_r1_fwd, w_r2_fwd;
  logic              w_lu;

  assign w_lu = hz.EX_MemRead && (hz.R1_EX_Related || hz.R2_EX_Related);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_halted     = 1'b0;
    w_r1_fwd     = fwd_sel(hz.R1_EX_Related, hz.R1_MEM_Related);
    w_r2_fwd     = fwd_sel(hz.R2_EX_Related, hz.R2_MEM_Related);

    case (r_state)
      RUN: begin
        if (hz.Halt) begin
          {w_pc_en, w_ifid_en, w_idex_flush} = 3'b001;
          w_next = HALTED;
        end else if (hz.Branch_Taken) begin
          // Wrong-path load-use or mul/div requests are dropped here.
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
        end else if (w_lu) begin
          {w_pc_en, w_ifid_en, w_idex_flush} = 3'b001;
          w_next = LOAD_STALL;
        end else if (hz.MulDiv_Start) begin
          w_next       = MD_BUSY;
          w_md_cnt_nxt = c_MD_LOAD;
        end
      end
      LOAD_STALL: begin
        // EX holds the bubble, so any load-use seen now is stale.
        if (hz.Halt) begin
          {w_pc_en, w_ifid_en, w_idex_flush} = 3'b001;
          w_next = HALTED;
        end else begin
          w_next = RUN;
        end
      end
      MD_BUSY: begin
        {w_pc_en, w_ifid_en, w_idex_flush} = 3'b001;
        if (hz.Halt)
          w_next = HALTED;
        else if (r_md_cnt == '0)
          w_next = RUN;
        else
          w_md_cnt_nxt = r_md_cnt - 1'b1;
      end
      HALTED: begin
        {w_pc_en, w_ifid_en, w_idex_flush} = 3'b001;
        w_halted = 1'b1;
        w_r1_fwd = FWD_RF;
        w_r2_fwd = FWD_RF;
      end
      default: w_next = RUN;
    endcase
  end

  assign hz.PC_En      = w_pc_en;
  assign hz.IFID_En    = w_ifid_en;
  assign hz.IFID_Flush = w_ifid_flush;
  assign hz.IDEX_Flush = w_idex_flush;
  assign hz.R1_Fwd     = w_r1_fwd;
  assign hz.R2_Fwd     = w_r2_fwd;
  assign hz.Halted     = w_halted;

`ifdef HAZARD_PERF_CNT_EN
  logic w_stall_inc;

  // Frozen-by-halt cycles are not stalls the pipeline will recover from.
  assign w_stall_inc = !w_pc_en && (r_state != HALTED);

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .count (hz.Stall_Cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_ifid_flush),
    .count (hz.Flush_Cnt)
  );
`else
  assign hz.Stall_Cnt = {CNT_W{1'b0}};
  assign hz.Flush_Cnt = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
//============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Scoreboard bench for pipeline_hazard_ctrl (MD_LATENCY=4, CNT_W=4).
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam int         c_CNT_W = 4;
  localparam logic [3:0] c_NORM  = 4'b1100;  // {PC_En, IFID_En, IFID_Flush, IDEX_Flush}
  localparam logic [3:0] c_FRZ   = 4'b0001;
  localparam logic [3:0] c_BR    = 4'b1111;
  localparam logic [7:0] c_IDLE  = 8'b0000_0000;
  localparam logic [7:0] c_MD    = 8'b0000_0010;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [3:0] c_EXP_STALL = 4'd15;
`else
  localparam logic [3:0] c_EXP_STALL = 4'd0;
`endif

  typedef struct {
    string      name;
    logic [3:0] ctl;
    logic [1:0] r1;
    logic [1:0] r2;
    logic       halted;
    bit         chk_cnt;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t q[$];

  pipeline_hazard_ctrl_if #(.CNT_W(c_CNT_W)) hz ();

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(c_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs ordered {R1_EX, R1_MEM, R2_EX, R2_MEM, EX_MemRead, Branch, MulDiv, Halt}
  task automatic drive(input logic [7:0] vin);
    {hz.R1_EX_Related, hz.R1_MEM_Related, hz.R2_EX_Related, hz.R2_MEM_Related,
     hz.EX_MemRead, hz.Branch_Taken, hz.MulDiv_Start, hz.Halt} = vin;
  endtask

  task automatic push(input string nm, input logic [3:0] ctl, input logic [1:0] r1,
                      input logic [1:0] r2, input logic h, input bit cc,
                      input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    e.name = nm; e.ctl = ctl; e.r1 = r1; e.r2 = r2; e.halted = h;
    e.chk_cnt = cc; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic step(input string nm, input logic [7:0] vin, input logic [3:0] ctl,
                      input logic [1:0] r1, input logic [1:0] r2, input logic h);
    @(posedge clk);
    #1;
    drive(vin);
    push(nm, ctl, r1, r2, h, 1'b0, 4'd0, 4'd0);
  endtask

  // Monitor: outputs are combinational, so the mid-cycle falling edge sees them settled.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [3:0] act_ctl;
      e = q.pop_front();
      act_ctl = {hz.PC_En, hz.IFID_En, hz.IFID_Flush, hz.IDEX_Flush};
      tests++;
      if (act_ctl !== e.ctl || hz.R1_Fwd !== e.r1 || hz.R2_Fwd !== e.r2 ||
          hz.Halted !== e.halted ||
          (e.chk_cnt && (hz.Stall_Cnt !== e.sc || hz.Flush_Cnt !== e.fc))) begin
        fails++;
        $display("FAIL %s: got ctl=%b r1=%b r2=%b halted=%b stall=%0d flush=%0d; expected ctl=%b r1=%b r2=%b halted=%b stall=%0d flush=%0d%s",
                 e.name, act_ctl, hz.R1_Fwd, hz.R2_Fwd, hz.Halted, hz.Stall_Cnt,
                 hz.Flush_Cnt, e.ctl, e.r1, e.r2, e.halted, e.sc, e.fc,
                 e.chk_cnt ? "" : " (counters not checked)");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(c_IDLE);
    repeat (2) @(posedge clk);
    step("reset_idle", c_IDLE, c_NORM, FWD_RF, FWD_RF, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Load-use bubble then MEM forwarding
    step("lu_stall",      8'b1000_1000, c_FRZ,  FWD_EX,  FWD_RF,  1'b0);
    step("lu_mem_fwd",    8'b0100_0000, c_NORM, FWD_MEM, FWD_RF,  1'b0);
    step("idle_run",      c_IDLE,       c_NORM, FWD_RF,  FWD_RF,  1'b0);
    step("r2_ex_over_mem",8'b0011_0000, c_NORM, FWD_RF,  FWD_EX,  1'b0);
    step("r2_mem_only",   8'b0001_0000, c_NORM, FWD_RF,  FWD_MEM, 1'b0);
    // Branch beats load-use; the following LU stalls, proving no LOAD_STALL was entered
    step("br_vs_lu",      8'b1000_1100, c_BR,   FWD_EX,  FWD_RF,  1'b0);
    step("lu_after_br",   8'b1000_1000, c_FRZ,  FWD_EX,  FWD_RF,  1'b0);
    step("lu_in_stall",   8'b1000_1000, c_NORM, FWD_EX,  FWD_RF,  1'b0);
    // Mul/div window of 4, restart attempt inside does not extend it
    step("md_issue",      c_MD,   c_NORM, FWD_RF, FWD_RF, 1'b0);
    step("md_w1_restart", c_MD,   c_FRZ,  FWD_RF, FWD_RF, 1'b0);
    step("md_w2",         c_IDLE, c_FRZ,  FWD_RF, FWD_RF, 1'b0);
    step("md_w3",         c_IDLE, c_FRZ,  FWD_RF, FWD_RF, 1'b0);
    step("md_w4",         c_IDLE, c_FRZ,  FWD_RF, FWD_RF, 1'b0);
    step("md_done",       c_IDLE, c_NORM, FWD_RF, FWD_RF, 1'b0);
    // Halt inside the window
    step("md2_issue",     c_MD,         c_NORM, FWD_RF, FWD_RF, 1'b0);
    step("md2_w1",        c_IDLE,       c_FRZ,  FWD_RF, FWD_RF, 1'b0);
    step("md2_w2_halt",   8'b0000_0001, c_FRZ,  FWD_RF, FWD_RF, 1'b0);
    step("halted_nofwd",  8'b1000_0000, c_FRZ,  FWD_RF, FWD_RF, 1'b1);
    step("halted_branch", 8'b0000_0100, c_FRZ,  FWD_RF, FWD_RF, 1'b1);

    // Asynchronous reset mid-cycle: outputs revert before the next edge
    @(posedge clk);
    #1 drive(c_IDLE);
    #1 rst_n = 1'b0;
    push("async_reset", c_NORM, FWD_RF, FWD_RF, 1'b0, 1'b1, 4'd0, 4'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("post_reset", c_IDLE, c_NORM, FWD_RF, FWD_RF, 1'b0);

    // 5 x (issue + 4 stalls) = 20 stall cycles, counter saturates at 15
    for (int r = 0; r < 5; r++) begin
      step("perf_md_issue", c_MD, c_NORM, FWD_RF, FWD_RF, 1'b0);
      for (int k = 0; k < 4; k++)
        step("perf_md_stall", c_IDLE, c_FRZ, FWD_RF, FWD_RF, 1'b0);
    end
    @(posedge clk);
    #1 drive(c_IDLE);
    push("stall_cnt_sat", c_NORM, FWD_RF, FWD_RF, 1'b0, 1'b1, c_EXP_STALL, 4'd0);

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
